// File: rtl/idli_pkg.sv
// Shared types and opcodes for the idli SQI SRAM interface.
package idli_pkg;

    typedef logic [3:0] slice_t;

    typedef enum logic [3:0] {
        ST_RSTQ,
        ST_GAP,
        ST_EQIO,
        ST_HOLD,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA
    } sqi_state_t;

    localparam logic [7:0] SQI_OP_READ   = 8'h03;
    localparam logic [7:0] SQI_OP_WRITE  = 8'h02;
    localparam logic [7:0] SQI_OP_EQIO   = 8'h38;
    localparam logic [7:0] SQI_OP_RSTQIO = 8'hFF;

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// Single-bank SQI SRAM sequencer: puts the device in quad mode after reset, then
// turns one-word read/write requests into CMD/ADDR/[DUMMY]/DATA nibble streams.
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int DUMMY_NIB = 2,
    parameter int CS_HOLD   = 2
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst,
    input  logic        i_sqi_req_vld,
    output logic        o_sqi_req_rdy,
    input  logic        i_sqi_req_wr,
    input  logic [15:0] i_sqi_req_addr,
    input  logic [15:0] i_sqi_req_data,
    output logic        o_sqi_rd_vld,
    output logic [15:0] o_sqi_rd_data,
    output logic        o_sqi_sck,
    output logic        o_sqi_cs,
    input  slice_t      i_sqi_sio,
    output slice_t      o_sqi_sio,
    output logic        o_sqi_sio_oe
);

    localparam int HW = $clog2(CS_HOLD + 1);

    sqi_state_t      state_q, state_d, nxt_st;
    logic            run_q;
    logic            phase_q, phase_d;
    logic [2:0]      slot_q, slot_d, last_idx;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [23:0]     out_q, out_d;
    logic [15:0]     dat_q, dat_d;
    logic            wr_q, wr_d;
    logic            rd_vld_q, rd_vld_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic            busy;

    // run_q holds off the first RSTQ slot for one cycle so the outputs sit
    // at their idle values for as long as reset is applied.
    assign busy = run_q && (state_q inside {ST_RSTQ, ST_EQIO, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});

    always_comb begin
        last_idx = 3'd0;
        nxt_st   = state_q;
        case (state_q)
            ST_RSTQ:  begin last_idx = 3'd1; nxt_st = ST_GAP;  end
            ST_EQIO:  begin last_idx = 3'd7; nxt_st = ST_HOLD; end
            ST_CMD:   begin last_idx = 3'd1; nxt_st = ST_ADDR; end
            ST_ADDR:  begin
                last_idx = 3'd3;
                nxt_st   = (!wr_q && DUMMY_NIB > 0) ? ST_DUMMY : ST_DATA;
            end
            ST_DUMMY: begin last_idx = 3'(DUMMY_NIB - 1); nxt_st = ST_DATA; end
            ST_DATA:  begin last_idx = 3'd3; nxt_st = ST_HOLD; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        slot_d    = slot_q;
        hcnt_d    = hcnt_q;
        out_d     = out_q;
        dat_d     = dat_q;
        wr_d      = wr_q;
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_GAP, ST_HOLD: begin
                hcnt_d = hcnt_q + HW'(1);
                if (hcnt_q == HW'(CS_HOLD - 1)) begin
                    hcnt_d  = '0;
                    state_d = (state_q == ST_GAP) ? ST_EQIO : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_sqi_req_vld) begin
                    wr_d    = i_sqi_req_wr;
                    out_d   = {i_sqi_req_wr ? SQI_OP_WRITE : SQI_OP_READ, i_sqi_req_addr};
                    dat_d   = i_sqi_req_data;
                    state_d = ST_CMD;
                end
            end
            default: begin
                if (run_q) begin
                    phase_d = ~phase_q;
                    // Slot ends on the edge closing phase1: advance shifters, sample SIO.
                    if (phase_q) begin
                        slot_d = slot_q + 3'd1;
                        case (state_q)
                            ST_EQIO:         out_d = {out_q[22:0], 1'b0};
                            ST_CMD, ST_ADDR: out_d = {out_q[19:0], 4'h0};
                            ST_DATA:         dat_d = {dat_q[11:0], wr_q ? 4'h0 : i_sqi_sio};
                            default:         ;
                        endcase
                        if (slot_q == last_idx) begin
                            slot_d  = '0;
                            state_d = nxt_st;
                            if (state_q == ST_DATA && !wr_q) begin
                                rd_vld_d  = 1'b1;
                                rd_data_d = {dat_q[11:0], i_sqi_sio};
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            state_q   <= ST_RSTQ;
            run_q     <= 1'b0;
            phase_q   <= 1'b0;
            slot_q    <= '0;
            hcnt_q    <= '0;
            out_q     <= {SQI_OP_EQIO, 16'h0000};
            dat_q     <= '0;
            wr_q      <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            phase_q   <= phase_d;
            slot_q    <= slot_d;
            hcnt_q    <= hcnt_d;
            out_q     <= out_d;
            dat_q     <= dat_d;
            wr_q      <= wr_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        o_sqi_sio = 4'h0;
        if (busy) begin
            case (state_q)
                ST_RSTQ:         o_sqi_sio = SQI_OP_RSTQIO[7:4];
                ST_EQIO:         o_sqi_sio = {3'b000, out_q[23]};
                ST_CMD, ST_ADDR: o_sqi_sio = out_q[23:20];
                ST_DATA:         o_sqi_sio = wr_q ? dat_q[15:12] : 4'h0;
                default:         o_sqi_sio = 4'h0;
            endcase
        end
    end

    // Bus turns around at the start of DUMMY (a phase0 cycle), so oe never moves with sck high.
    assign o_sqi_sio_oe  = busy && !(state_q == ST_DUMMY || (state_q == ST_DATA && !wr_q));
    assign o_sqi_cs      = ~busy;
    assign o_sqi_sck     = busy & phase_q;
    assign o_sqi_req_rdy = (state_q == ST_IDLE);
    assign o_sqi_rd_vld  = rd_vld_q;
    assign o_sqi_rd_data = rd_data_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m with a nibble-level SQI SRAM read model.
module tb_idli_sqi_ctrl_m;
    import idli_pkg::*;

    logic        gck = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        rdy;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdat = '0;
    logic        rdv;
    logic [15:0] rdd;
    logic        sck, cs, oe;
    slice_t      sio_in = '0;
    slice_t      sio_out;

    int n_tot = 0;
    int n_bad = 0;

    logic [15:0] mem_word = '0;
    int          slot_n = 0;
    int          rdv_total = 0;
    logic        nxt_wr = 1'b0;
    logic [15:0] nxt_addr = '0;

    int          w_cslow, w_csrise, w_csfall, w_csfalls, w_nibn, w_oe0, w_oe0n;
    int          w_rdvn, w_rdv_at, w_rdy_at, w_sckhi_csh, w_oechg;
    logic [63:0] w_nib;
    logic [15:0] w_rdd;

    idli_sqi_ctrl_m dut (
        .i_sqi_gck      (gck),
        .i_sqi_rst      (rst),
        .i_sqi_req_vld  (vld),
        .o_sqi_req_rdy  (rdy),
        .i_sqi_req_wr   (wr),
        .i_sqi_req_addr (addr),
        .i_sqi_req_data (wdat),
        .o_sqi_rd_vld   (rdv),
        .o_sqi_rd_data  (rdd),
        .o_sqi_sck      (sck),
        .o_sqi_cs       (cs),
        .i_sqi_sio      (sio_in),
        .o_sqi_sio      (sio_out),
        .o_sqi_sio_oe   (oe)
    );

    always #5 gck = ~gck;

    // SRAM read model: CMD(2)+ADDR(4)+DUMMY(2) slots, then 4 data nibbles MSB first.
    always @(negedge gck) begin
        if (rst || cs) begin
            slot_n = 0;
            sio_in = 4'h0;
        end else if (sck) begin
            slot_n++;
        end else if (slot_n >= 8 && slot_n < 12) begin
            sio_in = mem_word[15 - 4 * (slot_n - 8) -: 4];
        end else begin
            sio_in = 4'h0;
        end
        if (rdv) rdv_total++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic init_seq();
        logic [15:0] rs;
        logic [7:0]  eq;
        int low_a, gap_hi, low_b, hold_hi;
        logic hi3, rdy_early, rdy_fin;
        rs = '0; eq = '0; low_a = 0; gap_hi = 0; low_b = 0; hold_hi = 0;
        hi3 = 1'b0; rdy_early = 1'b0; rdy_fin = 1'b0;
        @(negedge gck);
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge gck);
            if (k < 4) begin
                rs = {rs[11:0], sio_out};
                if (!cs) low_a++;
            end else if (k < 6) begin
                if (cs) gap_hi++;
            end else if (k < 22) begin
                if (!cs) low_b++;
                if (sck) eq = {eq[6:0], sio_out[0]};
                hi3 = hi3 | (|sio_out[3:1]);
            end else if (k < 24) begin
                if (cs) hold_hi++;
            end
            if (k < 24) rdy_early = rdy_early | rdy;
            else rdy_fin = rdy;
        end
        chk("init_rstq_nib", rs, 16'hFFFF);
        chk("init_rstq_cs", low_a, 4);
        chk("init_gap", gap_hi, 2);
        chk("init_eqio", eq, 8'h38);
        chk("init_eqio_cs", low_b, 16);
        chk("init_eqio_hi3", hi3, 0);
        chk("init_hold", hold_hi, 2);
        chk("init_rdy_early", rdy_early, 0);
        chk("init_rdy", rdy_fin, 1);
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        for (int t = 0; t < 100 && !rdy; t++) @(negedge gck);
        if (!rdy) chk("rdy_timeout", rdy, 1);
        wr = w; addr = a; wdat = d; vld = 1'b1;
    endtask

    // Observe n cycles after the acceptance edge (i=0 is the first cycle after it).
    task automatic win(input int n, input bit hold, input int pulse_at);
        logic pcs, poe;
        bit drop;
        pcs = 1'b0; poe = 1'b1; drop = 1'b0;
        w_cslow = 0; w_csrise = -1; w_csfall = -1; w_csfalls = 0; w_nibn = 0; w_oe0 = -1;
        w_oe0n = 0; w_rdvn = 0; w_rdv_at = -1; w_rdy_at = -1; w_sckhi_csh = 0; w_oechg = 0;
        w_nib = '0; w_rdd = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge gck);
            if (i == 0 && !hold) vld = 1'b0;
            if (i == 0 && hold) begin wr = nxt_wr; addr = nxt_addr; end
            if (drop) begin vld = 1'b0; drop = 1'b0; end
            if (pulse_at > 0 && i == pulse_at) vld = 1'b1;
            if (pulse_at > 0 && i == pulse_at + 1) vld = 1'b0;
            if (!cs) w_cslow++;
            if (cs && !pcs && w_csrise < 0) w_csrise = i;
            if (!cs && pcs) begin w_csfalls++; if (w_csfall < 0) w_csfall = i; end
            if (!cs && sck && oe) begin w_nib = {w_nib[59:0], sio_out}; w_nibn++; end
            if (!cs && !oe) begin w_oe0n++; if (w_oe0 < 0) w_oe0 = i; end
            if (rdv) begin w_rdvn++; if (w_rdv_at < 0) w_rdv_at = i; w_rdd = rdd; end
            if (rdy && w_rdy_at < 0) w_rdy_at = i;
            if (cs && sck) w_sckhi_csh++;
            if (sck && oe != poe) w_oechg++;
            if (hold && rdy) drop = 1'b1;
            pcs = cs; poe = oe;
        end
    endtask

    initial begin
        int rdv0;
        repeat (3) @(negedge gck);
        chk("rst_cs_sck_oe", {cs, sck, oe}, 3'b100);
        chk("rst_rdy_rdv", {rdy, rdv}, 2'b00);
        chk("rst_rd_data", rdd, 16'h0000);
        chk("rst_sio", sio_out, 4'h0);

        init_seq();

        // single write
        issue(1'b1, 16'h1234, 16'hBEEF);
        win(26, 1'b0, 0);
        chk("wr_nib", w_nib[39:0], 40'h021234BEEF);
        chk("wr_nibn", w_nibn, 10);
        chk("wr_cslow", w_cslow, 20);
        chk("wr_csrise", w_csrise, 20);
        chk("wr_oe0n", w_oe0n, 0);
        chk("wr_rdy_at", w_rdy_at, 22);
        chk("wr_rdvn", w_rdvn, 0);

        // single read
        mem_word = 16'hC3A7;
        issue(1'b0, 16'h00A5, 16'h0000);
        win(30, 1'b0, 0);
        chk("rd_nib", w_nib[23:0], 24'h0300A5);
        chk("rd_nibn", w_nibn, 6);
        chk("rd_oe0", w_oe0, 12);
        chk("rd_vld_at", w_rdv_at, 24);
        chk("rd_vldn", w_rdvn, 1);
        chk("rd_data", w_rdd, 16'hC3A7);
        chk("rd_csrise", w_csrise, 24);
        chk("rd_oechg", w_oechg, 0);
        chk("rd_hold", rdd, 16'hC3A7);

        // back-to-back write then read, valid held throughout
        mem_word = 16'h9D61;
        nxt_wr = 1'b0; nxt_addr = 16'h5A0F;
        issue(1'b1, 16'h1234, 16'hBEEF);
        win(52, 1'b1, 0);
        chk("b2b_nib", w_nib, 64'h021234BEEF035A0F);
        chk("b2b_csrise", w_csrise, 20);
        chk("b2b_rdy_at", w_rdy_at, 22);
        chk("b2b_csfall", w_csfall, 23);
        chk("b2b_sck_idle", w_sckhi_csh, 0);
        chk("b2b_rd_at", w_rdv_at, 47);
        chk("b2b_rd_data", w_rdd, 16'h9D61);

        // valid pulsed while busy must be dropped
        issue(1'b1, 16'h0F0F, 16'h55AA);
        wdat = 16'h55AA;
        win(30, 1'b0, 5);
        chk("busy_csfalls", w_csfalls, 0);
        chk("busy_cslow", w_cslow, 20);
        chk("busy_nib", w_nib[39:0], 40'h020F0F55AA);
        chk("busy_idle", {rdy, cs}, 2'b11);
        chk("busy_rd_held", rdd, 16'h9D61);

        // reset during read ADDR phase (applied while sck is high)
        mem_word = 16'h1111;
        issue(1'b0, 16'h7777, 16'h0000);
        win(7, 1'b0, 0);
        rdv0 = rdv_total;
        @(posedge gck);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cs_oe_sck", {cs, oe, sck}, 3'b100);
        chk("mid_rst_rd", {rdv, rdd}, 17'h0);
        repeat (4) @(negedge gck);
        init_seq();
        chk("mid_rst_no_rdv", rdv_total - rdv0, 0);

        mem_word = 16'h4E2B;
        issue(1'b0, 16'hFFFE, 16'h0000);
        win(30, 1'b0, 0);
        chk("post_rd_nib", w_nib[23:0], 24'h03FFFE);
        chk("post_rd_at", w_rdv_at, 24);
        chk("post_rd_data", w_rdd, 16'h4E2B);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
